// File: rtl/butterfly_dif_pkg.sv
// Shared definitions for the radix-2 DIF butterfly: FSM encoding and Q-format defaults.
// Optional per-stage 1/2 scaling is selected by defining BFLY_SCALE_EN.
package butterfly_dif_pkg;

    localparam int WORD_SIZE_DEF = 16;
    localparam int FRACTION_DEF  = 8;
    localparam int ONE           = 1 << FRACTION_DEF;
    localparam int MUL_STEPS     = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DIFF,
        ST_MUL,
        ST_COMB,
        ST_OUT
    } state_t;

endpackage

// File: rtl/butterfly_dif_if.sv
// Operand/result handshake bundle between operand memory, butterfly and result writer.
interface butterfly_dif_if
    import butterfly_dif_pkg::*;
#(
    parameter int WORD_SIZE = WORD_SIZE_DEF
);
    logic                        i_valid;
    logic                        o_ready;
    logic signed [WORD_SIZE-1:0] i_in0_re, i_in0_im;
    logic signed [WORD_SIZE-1:0] i_in1_re, i_in1_im;
    logic signed [WORD_SIZE-1:0] i_tw_re, i_tw_im;
    logic                        i_inverse;
    logic                        o_valid;
    logic                        i_ready;
    logic signed [WORD_SIZE-1:0] o_out0_re, o_out0_im;
    logic signed [WORD_SIZE-1:0] o_out1_re, o_out1_im;

    modport slave (
        input  i_valid, i_in0_re, i_in0_im, i_in1_re, i_in1_im,
               i_tw_re, i_tw_im, i_inverse, i_ready,
        output o_ready, o_valid, o_out0_re, o_out0_im, o_out1_re, o_out1_im
    );

    modport master (
        output i_valid, i_in0_re, i_in0_im, i_in1_re, i_in1_im,
               i_tw_re, i_tw_im, i_inverse, i_ready,
        input  o_ready, o_valid, o_out0_re, o_out0_im, o_out1_re, o_out1_im
    );

endinterface

// File: rtl/butterfly_dif_fx_mul.sv
// Signed fixed-point multiply: full-width product, arithmetic >> FRACTION, truncate.
module fx_mul
    import butterfly_dif_pkg::*;
#(
    parameter int WORD_SIZE = WORD_SIZE_DEF,
    parameter int FRACTION  = FRACTION_DEF
) (
    input  logic signed [WORD_SIZE-1:0] a,
    input  logic signed [WORD_SIZE-1:0] b,
    output logic signed [WORD_SIZE-1:0] p
);
    logic signed [2*WORD_SIZE-1:0] prod;

    assign prod = a * b;
    // Truncation wraps; -1.0 * -1.0 deliberately does not saturate.
    assign p    = WORD_SIZE'(prod >>> FRACTION);

endmodule

// File: rtl/butterfly_dif.sv
// Radix-2 DIF butterfly: out0 = in0 + in1, out1 = (in0 - in1) * W (conj(W) when inverse).
// One shared real multiplier, four passes; BFLY_SCALE_EN halves sum/difference.
module butterfly_dif
    import butterfly_dif_pkg::*;
#(
    parameter int WORD_SIZE = WORD_SIZE_DEF,
    parameter int FRACTION  = FRACTION_DEF
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    butterfly_dif_if.slave bus
);
    typedef logic signed [WORD_SIZE-1:0] word_t;

    state_t     state_q, state_d;
    logic [1:0] k_q;
    logic       inv_q;
    word_t      in0_re_q, in0_im_q, in1_re_q, in1_im_q, tw_re_q, tw_im_q;
    word_t      d_re_q, d_im_q;
    word_t      p_q [MUL_STEPS];
    word_t      out0_re_q, out0_im_q, out1_re_q, out1_im_q;
    word_t      s_re, s_im, d_re, d_im;
    word_t      mul_a, mul_b, mul_p;

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (bus.i_valid) state_d = ST_DIFF;
            ST_DIFF: state_d = ST_MUL;
            ST_MUL:  if (k_q == 2'(MUL_STEPS - 1)) state_d = ST_COMB;
            ST_COMB: state_d = ST_OUT;
            ST_OUT:  if (bus.i_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.o_ready = (state_q == ST_IDLE);
        bus.o_valid = (state_q == ST_OUT);
    end

    assign bus.o_out0_re = out0_re_q;
    assign bus.o_out0_im = out0_im_q;
    assign bus.o_out1_re = out1_re_q;
    assign bus.o_out1_im = out1_im_q;

`ifdef BFLY_SCALE_EN
    // One guard bit so the halved result is exact instead of wrapping first.
    logic signed [WORD_SIZE:0] s_re_x, s_im_x, d_re_x, d_im_x;
    always_comb begin
        s_re_x = {in0_re_q[WORD_SIZE-1], in0_re_q} + {in1_re_q[WORD_SIZE-1], in1_re_q};
        s_im_x = {in0_im_q[WORD_SIZE-1], in0_im_q} + {in1_im_q[WORD_SIZE-1], in1_im_q};
        d_re_x = {in0_re_q[WORD_SIZE-1], in0_re_q} - {in1_re_q[WORD_SIZE-1], in1_re_q};
        d_im_x = {in0_im_q[WORD_SIZE-1], in0_im_q} - {in1_im_q[WORD_SIZE-1], in1_im_q};
        s_re   = WORD_SIZE'(s_re_x >>> 1);
        s_im   = WORD_SIZE'(s_im_x >>> 1);
        d_re   = WORD_SIZE'(d_re_x >>> 1);
        d_im   = WORD_SIZE'(d_im_x >>> 1);
    end
`else
    always_comb begin
        s_re = in0_re_q + in1_re_q;
        s_im = in0_im_q + in1_im_q;
        d_re = in0_re_q - in1_re_q;
        d_im = in0_im_q - in1_im_q;
    end
`endif

    // Pass order k: d_re*w_re, d_im*w_im, d_re*w_im, d_im*w_re.
    always_comb begin
        mul_a = k_q[0] ? d_im_q : d_re_q;
        mul_b = (k_q[0] ^ k_q[1]) ? tw_im_q : tw_re_q;
    end

    fx_mul #(
        .WORD_SIZE (WORD_SIZE),
        .FRACTION  (FRACTION)
    ) u_fx_mul (
        .a (mul_a),
        .b (mul_b),
        .p (mul_p)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            k_q       <= '0;
            inv_q     <= 1'b0;
            in0_re_q  <= '0;
            in0_im_q  <= '0;
            in1_re_q  <= '0;
            in1_im_q  <= '0;
            tw_re_q   <= '0;
            tw_im_q   <= '0;
            d_re_q    <= '0;
            d_im_q    <= '0;
            out0_re_q <= '0;
            out0_im_q <= '0;
            out1_re_q <= '0;
            out1_im_q <= '0;
            // NOTE: the product array is four flops, not RAM, so it can and does take the async reset.
            for (int i = 0; i < MUL_STEPS; i++) p_q[i] <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: if (bus.i_valid) begin
                    in0_re_q <= bus.i_in0_re;
                    in0_im_q <= bus.i_in0_im;
                    in1_re_q <= bus.i_in1_re;
                    in1_im_q <= bus.i_in1_im;
                    tw_re_q  <= bus.i_tw_re;
                    tw_im_q  <= bus.i_tw_im;
                    inv_q    <= bus.i_inverse;
                end
                ST_DIFF: begin
                    out0_re_q <= s_re;
                    out0_im_q <= s_im;
                    d_re_q    <= d_re;
                    d_im_q    <= d_im;
                    k_q       <= '0;
                end
                ST_MUL: begin
                    p_q[k_q] <= mul_p;
                    k_q      <= k_q + 2'd1;
                end
                ST_COMB: begin
                    if (inv_q) begin
                        out1_re_q <= p_q[0] + p_q[1];
                        out1_im_q <= p_q[3] - p_q[2];
                    end else begin
                        out1_re_q <= p_q[0] - p_q[1];
                        out1_im_q <= p_q[2] + p_q[3];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_butterfly_dif.sv
// Self-checking bench for butterfly_dif: complex-arithmetic model plus hand-computed vectors.
// Expectations follow BFLY_SCALE_EN when it is defined for the build.
module tb_butterfly_dif;
    import butterfly_dif_pkg::*;

    typedef struct {
        logic [15:0] o0r, o0i, o1r, o1i;
        int          acc;
    } exp_t;

`ifdef BFLY_SCALE_EN
    localparam bit LIT_EN = 1'b0;
`else
    localparam bit LIT_EN = 1'b1;
`endif

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_checks;
    int   n_errors;
    bit   first;
    exp_t exp_q[$];

    butterfly_dif_if #(.WORD_SIZE(16)) bus ();

    butterfly_dif #(
        .WORD_SIZE (16),
        .FRACTION  (8)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got 0x%04h, required 0x%04h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic fail_bound(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
    endtask

    function automatic logic [15:0] fxm(input logic [15:0] a, input logic [15:0] b);
        longint pa, pb;
        pa = longint'($signed(a));
        pb = longint'($signed(b));
        return 16'((pa * pb) >>> FRACTION_DEF);
    endfunction

    // Complex butterfly from first principles, with per-product truncation.
    function automatic exp_t model(input logic [15:0] a_re, a_im, b_re, b_im, w_re, w_im,
                                   input logic inv);
        exp_t        e;
        longint      sr, si, dr, di;
        logic [15:0] d16r, d16i, p0, p1, p2, p3;
        sr = longint'($signed(a_re)) + longint'($signed(b_re));
        si = longint'($signed(a_im)) + longint'($signed(b_im));
        dr = longint'($signed(a_re)) - longint'($signed(b_re));
        di = longint'($signed(a_im)) - longint'($signed(b_im));
`ifdef BFLY_SCALE_EN
        sr = sr >>> 1;
        si = si >>> 1;
        dr = dr >>> 1;
        di = di >>> 1;
`endif
        e.o0r = 16'(sr);
        e.o0i = 16'(si);
        d16r  = 16'(dr);
        d16i  = 16'(di);
        p0 = fxm(d16r, w_re);
        p1 = fxm(d16i, w_im);
        p2 = fxm(d16r, w_im);
        p3 = fxm(d16i, w_re);
        e.o1r = inv ? p0 + p1 : p0 - p1;
        e.o1i = inv ? p3 - p2 : p2 + p3;
        e.acc = 0;
        return e;
    endfunction

    // Result comparison on every cycle the DUT presents a result.
    always @(negedge clk) begin
        if (rst_n && bus.o_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_valid: o_valid=1 with no operand set pending (cycle %0d)", cyc);
            end else begin
                check("out0_re", bus.o_out0_re, exp_q[0].o0r);
                check("out0_im", bus.o_out0_im, exp_q[0].o0i);
                check("out1_re", bus.o_out1_re, exp_q[0].o1r);
                check("out1_im", bus.o_out1_im, exp_q[0].o1i);
                check("ready_while_valid", 16'(bus.o_ready), 16'd0);
                if (first) check("latency", 16'(cyc - exp_q[0].acc), 16'd6);
                first = 1'b0;
                if (bus.i_ready) begin
                    void'(exp_q.pop_front());
                    first = 1'b1;
                end
            end
        end
    end

    task automatic op(input logic [15:0] a_re, a_im, b_re, b_im, w_re, w_im,
                      input logic inv, input bit keep_valid, input bit lit,
                      input logic [15:0] l0r, l0i, l1r, l1i);
        exp_t e;
        int   n;
        e = model(a_re, a_im, b_re, b_im, w_re, w_im, inv);
        if (lit) begin
            check("pin_out0_re", e.o0r, l0r);
            check("pin_out0_im", e.o0i, l0i);
            check("pin_out1_re", e.o1r, l1r);
            check("pin_out1_im", e.o1i, l1i);
        end
        n = 0;
        while (!bus.o_ready && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.o_ready) fail_bound("accept_wait");
        bus.i_valid   = 1'b1;
        bus.i_in0_re  = a_re;
        bus.i_in0_im  = a_im;
        bus.i_in1_re  = b_re;
        bus.i_in1_im  = b_im;
        bus.i_tw_re   = w_re;
        bus.i_tw_im   = w_im;
        bus.i_inverse = inv;
        e.acc = cyc + 1;
        exp_q.push_back(e);
        @(posedge clk); #1;
        // Scramble the ports: the captured copy must be the one used.
        bus.i_valid   = keep_valid;
        bus.i_in0_re  = ~a_re;
        bus.i_in1_re  = a_im;
        bus.i_tw_re   = w_im;
        bus.i_tw_im   = w_re;
        bus.i_inverse = ~inv;
        check("busy_not_ready", 16'(bus.o_ready), 16'd0);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !bus.o_ready) && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        if (exp_q.size() != 0 || !bus.o_ready) fail_bound("drain_wait");
    endtask

    task automatic test1();
`ifdef BFLY_SCALE_EN
        op(16'h0200, 16'h0100, 16'h0100, 16'h0000, 16'(ONE), 16'h0000, 1'b0, 1'b0, 1'b1,
           16'h0180, 16'h0080, 16'h0080, 16'h0080);
`else
        op(16'h0200, 16'h0100, 16'h0100, 16'h0000, 16'(ONE), 16'h0000, 1'b0, 1'b0, 1'b1,
           16'h0300, 16'h0100, 16'h0100, 16'h0100);
`endif
    endtask

    initial begin
        int n;
        cyc = 0; n_checks = 0; n_errors = 0; first = 1'b1;
        bus.i_valid = 1'b0; bus.i_ready = 1'b1; bus.i_inverse = 1'b0;
        bus.i_in0_re = '0; bus.i_in0_im = '0; bus.i_in1_re = '0; bus.i_in1_im = '0;
        bus.i_tw_re = '0; bus.i_tw_im = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 16'(bus.o_valid), 16'd0);
        check("rst_ready", 16'(bus.o_ready), 16'd1);
        check("rst_out0_re", bus.o_out0_re, 16'h0000);
        check("rst_out0_im", bus.o_out0_im, 16'h0000);
        check("rst_out1_re", bus.o_out1_re, 16'h0000);
        check("rst_out1_im", bus.o_out1_im, 16'h0000);
        @(negedge clk); #2 rst_n = 1'b1;
        @(posedge clk); #1;

        test1();
        op(16'h0200, 16'h0100, 16'h0100, 16'h0000, 16'h0000, 16'hFF00, 1'b0, 1'b0, LIT_EN,
           16'h0300, 16'h0100, 16'h0100, 16'hFF00);
        op(16'h0200, 16'h0100, 16'h0100, 16'h0000, 16'h0000, 16'hFF00, 1'b1, 1'b0, LIT_EN,
           16'h0300, 16'h0100, 16'hFF00, 16'h0100);
        op(16'h0080, 16'h0000, 16'h0000, 16'h0000, 16'h0080, 16'h0000, 1'b0, 1'b0, LIT_EN,
           16'h0080, 16'h0000, 16'h0040, 16'h0000);
        op(16'hFF80, 16'h0000, 16'h0000, 16'h0000, 16'h0080, 16'h0000, 1'b0, 1'b0, LIT_EN,
           16'hFF80, 16'h0000, 16'hFFC0, 16'h0000);
        op(16'h8000, 16'h0000, 16'h0000, 16'h0000, 16'h8000, 16'h0000, 1'b0, 1'b0, LIT_EN,
           16'h8000, 16'h0000, 16'h0000, 16'h0000);
        op(16'h7FFF, 16'h8000, 16'h0001, 16'h0001, 16'(ONE), 16'h0000, 1'b0, 1'b0, LIT_EN,
           16'h8000, 16'h8001, 16'h7FFE, 16'h7FFF);
        op(16'h1234, 16'hF00D, 16'h0567, 16'h0ACE, 16'hFF00, 16'h0000, 1'b1, 1'b0, 1'b0,
           16'h0, 16'h0, 16'h0, 16'h0);
        for (int i = 0; i < 6; i++) begin
            op(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
               16'($urandom), 16'($urandom), 1'($urandom), 1'b0, 1'b0,
               16'h0, 16'h0, 16'h0, 16'h0);
        end
        wait_drain();

        // Back-pressure: result held while downstream stalls and upstream keeps asserting valid.
        bus.i_ready = 1'b0;
        op(16'h0200, 16'h0100, 16'h0100, 16'h0000, 16'h0000, 16'hFF00, 1'b1, 1'b1, 1'b0,
           16'h0, 16'h0, 16'h0, 16'h0);
        n = 0;
        while (!bus.o_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.o_valid) fail_bound("hold_valid_wait");
        repeat (5) @(posedge clk);
        #1;
        bus.i_ready = 1'b1;
        bus.i_valid = 1'b0;
        @(posedge clk); #1;
        check("hold_release_ready", 16'(bus.o_ready), 16'd1);
        check("hold_release_valid", 16'(bus.o_valid), 16'd0);
        check("hold_queue_empty", 16'(exp_q.size()), 16'd0);

        // Asynchronous reset while the multiplier is being sequenced.
        test1();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_valid", 16'(bus.o_valid), 16'd0);
        check("midrst_ready", 16'(bus.o_ready), 16'd1);
        check("midrst_out0_re", bus.o_out0_re, 16'h0000);
        check("midrst_out0_im", bus.o_out0_im, 16'h0000);
        check("midrst_out1_re", bus.o_out1_re, 16'h0000);
        check("midrst_out1_im", bus.o_out1_im, 16'h0000);
        exp_q.delete();
        first = 1'b1;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("post_rst_idle_ready", 16'(bus.o_ready), 16'd1);
        test1();
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule
